// File: rtl/pol_win_sched_pkg.sv
// pol_win_sched_pkg: shared scheduler FSM encoding and default sizing for the pooling window scheduler.
package pol_win_sched_pkg;
    localparam int POOL_CORE_D = 6;
    localparam int IDX_WIDTH_D = 10;
    localparam int OST_WIDTH_D = 4;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH, S_DONE} state_t;
endpackage

// File: rtl/pol_win_sched_if.sv
// pol_win_sched_if: CCU / pooling-core / GLB / MIC signal bundle of the window scheduler.
// SCHCCU_DrainCyc exists only when POL_WIN_SCHED_PERF_EN is defined.
interface pol_win_sched_if #(
    parameter int POOL_CORE = pol_win_sched_pkg::POOL_CORE_D,
    parameter int IDX_WIDTH = pol_win_sched_pkg::IDX_WIDTH_D
);
    logic                 CCUSCH_Start;
    logic [IDX_WIDTH-1:0] CCUSCH_AddrBase;
    logic [IDX_WIDTH-1:0] CCUSCH_AddrEnd;
    logic [IDX_WIDTH-1:0] CCUSCH_WinSize;
    logic [POOL_CORE-1:0] POLSCH_CoreDone;
    logic                 SCH_AddrHs;
    logic                 SCH_OfmHs;
    logic [IDX_WIDTH-1:0] SCHMIC_AddrMin;
    logic [IDX_WIDTH-1:0] SCHMIC_AddrMax;
    logic                 SCHMIC_Rst;
    logic                 SCHCCU_Busy;
    logic                 SCHCCU_Done;
    logic [IDX_WIDTH-1:0] SCHCCU_WinIdx;
`ifdef POL_WIN_SCHED_PERF_EN
    logic [31:0]          SCHCCU_DrainCyc;
`endif

    modport master (
`ifdef POL_WIN_SCHED_PERF_EN
        input  SCHCCU_DrainCyc,
`endif
        output CCUSCH_Start, CCUSCH_AddrBase, CCUSCH_AddrEnd, CCUSCH_WinSize,
        output POLSCH_CoreDone, SCH_AddrHs, SCH_OfmHs,
        input  SCHMIC_AddrMin, SCHMIC_AddrMax, SCHMIC_Rst,
        input  SCHCCU_Busy, SCHCCU_Done, SCHCCU_WinIdx
    );

    modport slave (
`ifdef POL_WIN_SCHED_PERF_EN
        output SCHCCU_DrainCyc,
`endif
        input  CCUSCH_Start, CCUSCH_AddrBase, CCUSCH_AddrEnd, CCUSCH_WinSize,
        input  POLSCH_CoreDone, SCH_AddrHs, SCH_OfmHs,
        output SCHMIC_AddrMin, SCHMIC_AddrMax, SCHMIC_Rst,
        output SCHCCU_Busy, SCHCCU_Done, SCHCCU_WinIdx
    );
endinterface

// File: rtl/pol_ost_cnt.sv
// pol_ost_cnt: saturating outstanding-read counter with a sticky over/underflow flag.
module pol_ost_cnt #(
    parameter int W = pol_win_sched_pkg::OST_WIDTH_D
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    input  logic         err_clr,
    output logic [W-1:0] count,
    output logic         err
);
    logic up, dn;

    always_comb begin
        up = inc && !dec;
        dn = dec && !inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            count <= clr ? '0 : (up && !(&count)) ? count + 1'b1 : (dn && count != '0) ? count - 1'b1 : count;
            // a flush discards the cycle's handshakes, so it cannot raise the flag
            err   <= err_clr ? 1'b0 : err | (!clr && ((up && &count) || (dn && count == '0)));
        end
    end
endmodule

// File: rtl/pol_win_sched.sv
// pol_win_sched: walks [Base,End) in WinSize windows, gating each window on core completion and read drain.
// Optional POL_WIN_SCHED_PERF_EN adds the SCHCCU_DrainCyc drain-cycle counter.
module pol_win_sched
    import pol_win_sched_pkg::*;
#(
    parameter int POOL_CORE = POOL_CORE_D,
    parameter int IDX_WIDTH = IDX_WIDTH_D,
    parameter int OST_WIDTH = OST_WIDTH_D
) (
    input logic             clk,
    input logic             rst_n,
    pol_win_sched_if.slave  bus
);
    state_t               state;
    logic [IDX_WIDTH-1:0] min_q, max_q, idx_q, end_q, ws_q;
    logic                 mic_rst, busy, done;
    logic [POOL_CORE-1:0] core_done;
    logic                 start_ok;
    logic [IDX_WIDTH-1:0] lo, ws, lim, hi;
    logic [IDX_WIDTH:0]   sum;
    logic [OST_WIDTH-1:0] ost;
    logic                 err_unused;

    assign core_done = bus.POLSCH_CoreDone;

    // next window bound: from the live config on Start, from the latched config on a flush
    always_comb begin
        start_ok = state == S_IDLE && bus.CCUSCH_Start;
        lo       = state == S_IDLE ? bus.CCUSCH_AddrBase : max_q;
        ws       = state == S_IDLE ? bus.CCUSCH_WinSize : ws_q;
        lim      = state == S_IDLE ? bus.CCUSCH_AddrEnd : end_q;
        sum      = {1'b0, lo} + {1'b0, ws};
        hi       = sum > {1'b0, lim} ? lim : sum[IDX_WIDTH-1:0];
    end

    pol_ost_cnt #(.W(OST_WIDTH)) u_ost (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (bus.SCH_AddrHs),
        .dec     (bus.SCH_OfmHs),
        .clr     (mic_rst),
        .err_clr (start_ok),
        .count   (ost),
        .err     (err_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            min_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            end_q   <= '0;
            ws_q    <= '0;
            mic_rst <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            mic_rst <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: if (bus.CCUSCH_Start) begin
                    end_q <= bus.CCUSCH_AddrEnd;
                    ws_q  <= bus.CCUSCH_WinSize;
                    busy  <= 1'b1;
                    if (bus.CCUSCH_WinSize == '0 || bus.CCUSCH_AddrBase >= bus.CCUSCH_AddrEnd) begin
                        state <= S_DONE;
                    end else begin
                        state   <= S_RUN;
                        min_q   <= bus.CCUSCH_AddrBase;
                        max_q   <= hi;
                        idx_q   <= '0;
                        mic_rst <= 1'b1;
                    end
                end
                S_RUN: if (&core_done) state <= S_DRAIN;
                S_DRAIN: if (ost == '0) begin
                    if (max_q == end_q) begin
                        state <= S_DONE;
                        min_q <= '0;
                        max_q <= '0;
                    end else begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    state   <= S_RUN;
                    mic_rst <= 1'b1;
                    min_q   <= max_q;
                    max_q   <= hi;
                    idx_q   <= idx_q + 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    min_q <= '0;
                    max_q <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef POL_WIN_SCHED_PERF_EN
    logic [31:0] drain_cyc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drain_cyc <= '0;
        else drain_cyc <= start_ok ? '0 : state == S_DRAIN ? drain_cyc + 1'b1 : drain_cyc;
    end

    assign bus.SCHCCU_DrainCyc = drain_cyc;
`endif

    assign bus.SCHMIC_AddrMin = min_q;
    assign bus.SCHMIC_AddrMax = max_q;
    assign bus.SCHMIC_Rst     = mic_rst;
    assign bus.SCHCCU_Busy    = busy;
    assign bus.SCHCCU_Done    = done;
    assign bus.SCHCCU_WinIdx  = idx_q;
endmodule

// File: tb/tb_pol_win_sched.sv
// tb_pol_win_sched: directed scenarios for pol_win_sched checked every cycle against a window-list model.
module tb_pol_win_sched;
    import pol_win_sched_pkg::*;

    localparam int OST_MAX = 15;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_FLUSH = 3, M_DONE = 4;

    logic clk, rst_n;
    int   errors = 0, checks = 0;

    pol_win_sched_if #(.POOL_CORE(6), .IDX_WIDTH(10)) bus ();

    pol_win_sched #(.POOL_CORE(6), .IDX_WIDTH(10), .OST_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: a pass is the precomputed list of windows; phases advance on the spec's conditions
    int ph, m_min, m_max, m_idx, m_cnt, m_drain, nc;
    bit m_err, m_rst, m_done, m_busy, ready;
    int mq_lo[$], mq_hi[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = M_IDLE; m_min = 0; m_max = 0; m_idx = 0; m_cnt = 0; m_drain = 0;
            m_err = 0; m_rst = 0; m_done = 0; m_busy = 0;
            mq_lo.delete(); mq_hi.delete();
        end else begin
            ready = m_cnt == 0;
            nc = m_cnt + int'(bus.SCH_AddrHs) - int'(bus.SCH_OfmHs);
            if (m_rst) nc = 0;
            else if (nc > OST_MAX || nc < 0) begin
                m_err = 1;
                nc = nc < 0 ? 0 : OST_MAX;
            end
            m_cnt = nc;
            m_rst = 0;
            m_done = 0;
            case (ph)
                M_IDLE: if (bus.CCUSCH_Start) begin
                    m_err = 0; m_drain = 0; m_busy = 1;
                    mq_lo.delete(); mq_hi.delete();
                    if (bus.CCUSCH_WinSize != 0)
                        for (int a = int'(bus.CCUSCH_AddrBase); a < int'(bus.CCUSCH_AddrEnd); a += int'(bus.CCUSCH_WinSize)) begin
                            mq_lo.push_back(a);
                            mq_hi.push_back(a + int'(bus.CCUSCH_WinSize) > int'(bus.CCUSCH_AddrEnd) ? int'(bus.CCUSCH_AddrEnd) : a + int'(bus.CCUSCH_WinSize));
                        end
                    if (mq_lo.size() == 0) ph = M_DONE;
                    else begin
                        m_min = mq_lo.pop_front(); m_max = mq_hi.pop_front();
                        m_idx = 0; m_rst = 1; ph = M_RUN;
                    end
                end
                M_RUN: if (&bus.POLSCH_CoreDone) ph = M_DRAIN;
                M_DRAIN: begin
                    m_drain++;
                    if (ready) begin
                        if (mq_lo.size() == 0) begin ph = M_DONE; m_min = 0; m_max = 0; end
                        else ph = M_FLUSH;
                    end
                end
                M_FLUSH: begin
                    m_min = mq_lo.pop_front(); m_max = mq_hi.pop_front();
                    m_idx++; m_rst = 1; ph = M_RUN;
                end
                default: begin m_done = 1; m_busy = 0; ph = M_IDLE; end
            endcase
        end
    end

    always @(negedge clk) if (rst_n) begin
        chk("busy", 32'(bus.SCHCCU_Busy), 32'(m_busy));
        chk("done", 32'(bus.SCHCCU_Done), 32'(m_done));
        chk("mic_rst", 32'(bus.SCHMIC_Rst), 32'(m_rst));
        chk("addr_min", 32'(bus.SCHMIC_AddrMin), 32'(m_min));
        chk("addr_max", 32'(bus.SCHMIC_AddrMax), 32'(m_max));
        chk("win_idx", 32'(bus.SCHCCU_WinIdx), 32'(m_idx));
        chk("ost_cnt", 32'(dut.u_ost.count), 32'(m_cnt));
        chk("ost_err", 32'(dut.u_ost.err), 32'(m_err));
`ifdef POL_WIN_SCHED_PERF_EN
        chk("drain_cyc", bus.SCHCCU_DrainCyc, 32'(m_drain));
`endif
    end

    int wq_lo[$], wq_hi[$], wq_idx[$];
    int rst_cnt;
    always @(negedge clk) if (rst_n && bus.SCHMIC_Rst) begin
        wq_lo.push_back(int'(bus.SCHMIC_AddrMin));
        wq_hi.push_back(int'(bus.SCHMIC_AddrMax));
        wq_idx.push_back(int'(bus.SCHCCU_WinIdx));
        rst_cnt++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start(input int base, input int lim, input int ws);
        bus.CCUSCH_AddrBase = 10'(base);
        bus.CCUSCH_AddrEnd  = 10'(lim);
        bus.CCUSCH_WinSize  = 10'(ws);
        bus.CCUSCH_Start    = 1'b1;
        step();
        bus.CCUSCH_Start    = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int k;
        for (k = 0; k < lim; k++) begin
            @(negedge clk);
            if (bus.SCHCCU_Done) break;
        end
        chk("done_within_bound", 32'(k < lim), 32'd1);
        step();
    endtask

    task automatic lat_to_done(input int base, input int lim, input int ws, output int n);
        bus.CCUSCH_AddrBase = 10'(base);
        bus.CCUSCH_AddrEnd  = 10'(lim);
        bus.CCUSCH_WinSize  = 10'(ws);
        bus.CCUSCH_Start    = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            bus.CCUSCH_Start = 1'b0;
            n++;
            @(negedge clk);
            if (bus.SCHCCU_Done) break;
        end
        step();
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        bus.CCUSCH_Start = 0; bus.CCUSCH_AddrBase = 0; bus.CCUSCH_AddrEnd = 0; bus.CCUSCH_WinSize = 0;
        bus.POLSCH_CoreDone = '0; bus.SCH_AddrHs = 0; bus.SCH_OfmHs = 0;
        step(2);
        chk("reset_busy", 32'(bus.SCHCCU_Busy), 0);
        chk("reset_min", 32'(bus.SCHMIC_AddrMin), 0);
        chk("reset_max", 32'(bus.SCHMIC_AddrMax), 0);
        chk("reset_done", 32'(bus.SCHCCU_Done), 0);
        rst_n = 1'b1;
        step();

        // four windows over [0,100) with cores always done and no traffic
        wq_lo.delete(); wq_hi.delete(); wq_idx.delete();
        bus.POLSCH_CoreDone = '1;
        start(0, 100, 32);
        wait_done(60);
        chk("win_count", 32'(wq_lo.size()), 4);
        if (wq_lo.size() == 4) begin
            chk("win0_lo", 32'(wq_lo[0]), 0);   chk("win0_hi", 32'(wq_hi[0]), 32);
            chk("win1_lo", 32'(wq_lo[1]), 32);  chk("win1_hi", 32'(wq_hi[1]), 64);
            chk("win2_lo", 32'(wq_lo[2]), 64);  chk("win2_hi", 32'(wq_hi[2]), 96);
            chk("win3_lo", 32'(wq_lo[3]), 96);  chk("win3_hi", 32'(wq_hi[3]), 100);
            chk("win3_idx", 32'(wq_idx[3]), 3);
        end

        // degenerate passes complete without a flush
        rst_cnt = 0;
        lat_to_done(0, 100, 0, n);
        chk("ws0_done_latency", 32'(n), 2);
        lat_to_done(50, 50, 8, n);
        chk("empty_done_latency", 32'(n), 2);
        chk("degenerate_no_rst", 32'(rst_cnt), 0);

        // three outstanding reads hold DRAIN until all have returned
        wq_lo.delete(); wq_hi.delete(); wq_idx.delete();
        bus.POLSCH_CoreDone = '0;
        start(0, 20, 10);
        step();
        bus.SCH_AddrHs = 1; step(3); bus.SCH_AddrHs = 0;
        bus.POLSCH_CoreDone = '1;
        step(5);
        chk("drain_hold_cnt", 32'(dut.u_ost.count), 3);
        chk("drain_hold_max", 32'(bus.SCHMIC_AddrMax), 10);
        chk("drain_hold_rst", 32'(rst_cnt), 1);
        bus.SCH_OfmHs = 1; step(3); bus.SCH_OfmHs = 0;
        wait_done(40);
        chk("drain_win_count", 32'(wq_lo.size()), 2);
        if (wq_lo.size() == 2) chk("drain_win1_lo", 32'(wq_lo[1]), 10);

        // simultaneous handshakes, underflow, and Start ignored mid-RUN
        bus.POLSCH_CoreDone = '0;
        start(0, 20, 20);
        step();
        bus.SCH_AddrHs = 1; step(2);
        bus.SCH_OfmHs = 1; step();
        bus.SCH_AddrHs = 0; bus.SCH_OfmHs = 0;
        chk("both_hs_cnt", 32'(dut.u_ost.count), 2);
        start(100, 200, 5);
        step();
        chk("ignored_start_min", 32'(bus.SCHMIC_AddrMin), 0);
        chk("ignored_start_max", 32'(bus.SCHMIC_AddrMax), 20);
        chk("ignored_start_busy", 32'(bus.SCHCCU_Busy), 1);
        bus.SCH_OfmHs = 1; step(3); bus.SCH_OfmHs = 0;
        chk("underflow_cnt", 32'(dut.u_ost.count), 0);
        chk("underflow_err", 32'(dut.u_ost.err), 1);
        bus.POLSCH_CoreDone = '1;
        wait_done(20);

        // saturation in IDLE, then the sticky flag clears on Start
        bus.SCH_AddrHs = 1; step(17); bus.SCH_AddrHs = 0;
        chk("sat_cnt", 32'(dut.u_ost.count), 15);
        chk("sat_err", 32'(dut.u_ost.err), 1);
        start(0, 10, 0);
        chk("start_clears_err", 32'(dut.u_ost.err), 0);
        wait_done(5);

        // asynchronous reset while blocked in DRAIN
        bus.POLSCH_CoreDone = '0;
        start(0, 50, 10);
        step();
        bus.SCH_AddrHs = 1; step(); bus.SCH_AddrHs = 0;
        bus.POLSCH_CoreDone = '1;
        step(3);
        #3 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(bus.SCHCCU_Busy), 0);
        chk("async_max", 32'(bus.SCHMIC_AddrMax), 0);
        chk("async_cnt", 32'(dut.u_ost.count), 0);
        chk("async_state", 32'(dut.state), 32'(S_IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.POLSCH_CoreDone = '0;
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pol_win_sched.md
POL_WIN_SCHED -- requirements
Module: pol_win_sched

Interface
REQ-001 Parameter: POOL_CORE, default 6, number of pooling cores feeding the memory interface controller.
REQ-002 Parameter: IDX_WIDTH, default 10, GLB address width.
REQ-003 Parameter: OST_WIDTH, default 4, outstanding-read counter width.
REQ-004 Port: clk  in  1  sole clock; all state on its rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: CCUSCH_Start  in  1  pulse to begin a pass over the configured range.
REQ-007 Port: CCUSCH_AddrBase  in  IDX_WIDTH  first address of the pass (inclusive).
REQ-008 Port: CCUSCH_AddrEnd  in  IDX_WIDTH  end address of the pass (exclusive).
REQ-009 Port: CCUSCH_WinSize  in  IDX_WIDTH  window length in addresses.
REQ-010 Port: POLSCH_CoreDone  in  POOL_CORE  level; bit i = core i has no further request inside the current window.
REQ-011 Port: SCH_AddrHs  in  1  address handshake to GLB (AddrVld & AddrRdy).
REQ-012 Port: SCH_OfmHs  in  1  ofm-return handshake from GLB (OfmVld & OfmRdy).
REQ-013 Port: SCHMIC_AddrMin / SCHMIC_AddrMax  out  IDX_WIDTH each  current window [Min, Max).
REQ-014 Port: SCHMIC_Rst  out  1  one-cycle synchronous flush to the memory interface controller.
REQ-015 Port: SCHCCU_Busy  out  1  high in any state except IDLE.
REQ-016 Port: SCHCCU_Done  out  1  one-cycle pulse at pass completion.
REQ-017 Port: SCHCCU_WinIdx  out  IDX_WIDTH  index of the current window, 0-based.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN, FLUSH, DONE; all outputs registered.
REQ-019 IDLE: on CCUSCH_Start SHALL latch Base/End/WinSize; if WinSize==0 or Base>=End go DONE, else set Min=Base, WinIdx=0, assert SCHMIC_Rst for one cycle, go RUN.
REQ-020 Max SHALL be min(Min+WinSize, End), computed at IDX_WIDTH+1 bits so the sum never wraps.
REQ-021 RUN: when &POLSCH_CoreDone is 1, go DRAIN next cycle.
REQ-022 DRAIN: when outstanding count==0, go DONE if Max==End, else go FLUSH.
REQ-023 FLUSH (1 cycle): assert SCHMIC_Rst, set Min=previous Max, recompute Max, WinIdx+1, go RUN.
REQ-024 DONE (1 cycle): assert SCHCCU_Done, drive Min=Max=0, go IDLE.
REQ-025 Outstanding counter: +1 on SCH_AddrHs, -1 on SCH_OfmHs; both in one cycle leaves it unchanged.
REQ-026 Counter SHALL saturate at 2^OST_WIDTH-1 on increment and hold 0 on decrement at 0; both cases set an internal sticky error bit, cleared on Start.
REQ-027 Counter SHALL clear in the cycle SCHMIC_Rst is asserted.
REQ-028 CCUSCH_Start outside IDLE SHALL be ignored; config inputs are sampled only on an accepted Start.
REQ-029 Min==Max outside RUN/DRAIN/FLUSH, so the controller matches no address.

Reset
REQ-030 rst_n low SHALL force IDLE, all outputs 0, the counter 0 and the error bit 0, regardless of state.

Configuration
REQ-031 With POL_WIN_SCHED_PERF_EN defined, the block SHALL add output SCHCCU_DrainCyc (32 bits), counting DRAIN cycles per pass and cleared on Start; without it, neither the port nor the counter exist.

Structure
REQ-032 The FSM state encoding and OST_WIDTH default SHALL live in the shared POL package.
REQ-033 The outstanding counter SHALL be a sub-module, pol_ost_cnt (inc, dec, clr, count, err).

Verification
REQ-034 Base=0, End=100, WinSize=32, CoreDone held high with no traffic -> windows [0,32),[32,64),[64,96),[96,100); WinIdx 0..3; Done pulse after the fourth window.
REQ-035 WinSize=0 or Base=50, End=50 -> Done pulse 2 cycles after Start, SCHMIC_Rst never asserted.
REQ-036 3 AddrHs, then CoreDone=all-ones -> stays in DRAIN until the 3rd OfmHs; FLUSH begins the following cycle.
REQ-037 AddrHs and OfmHs in the same cycle with count=2 -> count stays 2; OfmHs at count 0 -> count 0 and error bit set.
REQ-038 Start pulsed mid-RUN -> ignored, window unchanged; rst_n low in DRAIN -> outputs 0 and IDLE immediately, without waiting for a clock edge.
REQ-039 With POL_WIN_SCHED_PERF_EN defined: 5 cycles blocked in DRAIN in each of 2 windows -> SCHCCU_DrainCyc reports 10 at Done.
